// File: rtl/aes_dma_sequencer_if.sv
// -----------------------------------------------------------------------------
// aes_dma_sequencer_if
//
// Purpose: bundles the word-transfer handshake towards the AHB master and the
// block handshake towards the AES core, as seen by the sequencer.
//
// Signals:
//   m_req, m_mode, m_addr, m_wdata  sequencer -> AHB master (request side)
//   m_ack, m_rdata, m_err           AHB master -> sequencer (completion side)
//   core_start, core_din            sequencer -> AES core
//   core_dout, core_done            AES core  -> sequencer
//
// Modports:
//   master : the sequencer (drives requests, receives completions)
//   slave  : the AHB master / AES core pair
// -----------------------------------------------------------------------------
interface aes_dma_sequencer_if;
    logic         m_req;
    logic         m_mode;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic         m_ack;
    logic [31:0]  m_rdata;
    logic         m_err;
    logic         core_start;
    logic [127:0] core_din;
    logic [127:0] core_dout;
    logic         core_done;

    modport master (
        output m_req, m_mode, m_addr, m_wdata, core_start, core_din,
        input  m_ack, m_rdata, m_err, core_dout, core_done
    );

    modport slave (
        input  m_req, m_mode, m_addr, m_wdata, core_start, core_din,
        output m_ack, m_rdata, m_err, core_dout, core_done
    );
endinterface

// File: rtl/aes_dma_sequencer.sv
// -----------------------------------------------------------------------------
// aes_dma_sequencer
//
// Purpose: bulk AES job sequencer. For each 128-bit block it fetches four
// words from the source region, hands the block to the AES core, waits for
// the result and writes four words to the destination region. After
// num_blocks blocks (or on a bus error) it pulses done.
//
// Ports:
//   hclk, hrst                 clock, asynchronous active-high reset
//   start                      one-cycle job request (ignored while busy)
//   src_addr, dst_addr         byte addresses of first source/destination word
//   num_blocks                 block count, sampled on an accepted start
//   busy, done, err            job status (err is sticky until next start)
//   bus                        AHB master / AES core handshakes (master modport)
//
// Optional feature: define AES_SEQ_TIMEOUT_EN to abort a transfer when m_ack
// has not arrived after TIMEOUT_CYC cycles of m_req.
// -----------------------------------------------------------------------------
module aes_dma_sequencer #(
    parameter int NB_W        = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 hclk,
    input  logic                 hrst,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [NB_W-1:0]      num_blocks,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    aes_dma_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CSTART, S_CWAIT, S_STORE, S_FINISH, S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      wc_q, wc_d;
    logic [NB_W-1:0] blk_q, blk_d;
    logic [31:0]     src_q, src_d, dst_q, dst_d;
    logic [127:0]    in_buf_q, in_buf_d, out_buf_q, out_buf_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic            m_req_q, m_req_d, m_mode_q, m_mode_d;
    logic [31:0]     m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic            core_start_q, core_start_d;
    logic [127:0]    core_din_q, core_din_d;

    logic [1:0]      wc_inc;
    logic            ack;
    logic            to_abort;

    assign wc_inc = wc_q + 2'd1;
    // An ack only counts while a request is actually outstanding.
    assign ack    = m_req_q & bus.m_ack;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = '0;
        to_abort = 1'b0;
        if (m_req_q && !bus.m_ack) begin
            to_cnt_d = to_cnt_q + 1'b1;
            to_abort = (to_cnt_d == TO_W'(TIMEOUT_CYC));
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) to_cnt_q <= '0;
        else      to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign to_abort           = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        wc_d         = wc_q;
        blk_d        = blk_q;
        src_d        = src_q;
        dst_d        = dst_q;
        in_buf_d     = in_buf_q;
        out_buf_d    = out_buf_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        m_req_d      = m_req_q;
        m_mode_d     = m_mode_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        core_start_d = 1'b0;
        core_din_d   = core_din_q;

        case (state_q)
            S_IDLE: begin
                // done_q is high only in the cycle right after FINISH; a
                // start coinciding with that pulse is dropped.
                if (start && !done_q) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    blk_d  = num_blocks;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    wc_d   = 2'd0;
                    if (num_blocks == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d  = S_FETCH;
                        m_req_d  = 1'b1;
                        m_mode_d = 1'b0;
                        m_addr_d = src_addr;
                    end
                end
            end

            S_FETCH: begin
                if (ack) begin
                    if (bus.m_err) begin
                        state_d = S_ABORT;
                        m_req_d = 1'b0;
                    end else begin
                        // Word 0 lands in [127:96]; ~wc selects the slot.
                        in_buf_d[{~wc_q, 5'b0} +: 32] = bus.m_rdata;
                        src_d    = src_q + 32'd4;
                        m_addr_d = src_q + 32'd4;
                        wc_d     = wc_inc;
                        if (wc_q == 2'd3) begin
                            m_req_d = 1'b0;
                            state_d = S_CSTART;
                        end
                    end
                end else if (to_abort) begin
                    state_d = S_ABORT;
                    m_req_d = 1'b0;
                end
            end

            S_CSTART: begin
                core_start_d = 1'b1;
                core_din_d   = in_buf_q;
                state_d      = S_CWAIT;
            end

            S_CWAIT: begin
                if (bus.core_done) begin
                    out_buf_d = bus.core_dout;
                    state_d   = S_STORE;
                    m_req_d   = 1'b1;
                    m_mode_d  = 1'b1;
                    m_addr_d  = dst_q;
                    m_wdata_d = bus.core_dout[127:96];
                end
            end

            S_STORE: begin
                if (ack) begin
                    if (bus.m_err) begin
                        state_d = S_ABORT;
                        m_req_d = 1'b0;
                    end else begin
                        dst_d     = dst_q + 32'd4;
                        m_addr_d  = dst_q + 32'd4;
                        wc_d      = wc_inc;
                        m_wdata_d = out_buf_q[{~wc_inc, 5'b0} +: 32];
                        if (wc_q == 2'd3) begin
                            blk_d = blk_q - 1'b1;
                            if (blk_q == NB_W'(1)) begin
                                state_d  = S_FINISH;
                                m_req_d  = 1'b0;
                                m_mode_d = 1'b0;
                            end else begin
                                // Next block's fetch follows without a gap.
                                state_d  = S_FETCH;
                                m_mode_d = 1'b0;
                                m_addr_d = src_q;
                            end
                        end
                    end
                end else if (to_abort) begin
                    state_d = S_ABORT;
                    m_req_d = 1'b0;
                end
            end

            S_ABORT: begin
                err_d   = 1'b1;
                state_d = S_FINISH;
            end

            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q      <= S_IDLE;
            wc_q         <= 2'd0;
            blk_q        <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            in_buf_q     <= '0;
            out_buf_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            m_req_q      <= 1'b0;
            m_mode_q     <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            core_start_q <= 1'b0;
            core_din_q   <= '0;
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            blk_q        <= blk_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            in_buf_q     <= in_buf_d;
            out_buf_q    <= out_buf_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            m_req_q      <= m_req_d;
            m_mode_q     <= m_mode_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            core_start_q <= core_start_d;
            core_din_q   <= core_din_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign bus.m_req      = m_req_q;
    assign bus.m_mode     = m_mode_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_wdata    = m_wdata_q;
    assign bus.core_start = core_start_q;
    assign bus.core_din   = core_din_q;

endmodule
